tdc_frame_tx: RTL and testbench
===============================

Name: tdc_frame_tx

Overview:
- Parametrised successor to the single-byte TDC top. Measures the width of a `stop` high pulse in clk cycles, using a counter of configurable width.
- Counter saturates at all-ones and flags overflow.
- Latches the result and serialises it LSB-byte-first to an external byte transmitter through an STT/EOT handshake.
- Sits between the external stop input and the RS-232 byte transmitter.

Parameters:
- CNT_W, 16, counter/measurement width in bits; multiple of 8, range 8..32; localparam NBYTES = CNT_W/8.
- SYNC_STAGES, 2, flip-flop stages in the stop input synchroniser; minimum 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- stop  input  1  asynchronous pulse to be measured; the measured interval is while stop is high.
- tx_eot  input  1  one-cycle end-of-transmission pulse from the byte transmitter.
- tx_data  output  8  byte presented to the transmitter.
- tx_stt  output  1  one-cycle start-transmission pulse.
- dato  output  CNT_W  last latched measurement.
- ovf  output  1  last measurement saturated.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the final byte's EOT is accepted.

Behaviour:
- Reset (async, active-high): all outputs 0, counter 0, byte index 0, synchroniser flops 0, FSM to IDLE. Takes effect immediately, including mid-count and mid-transmit; tx_stt drops without waiting for a clock.
- Synchroniser: s = stop delayed through SYNC_STAGES flops. s_d = s delayed one more cycle. rise = s & ~s_d.
- IDLE:
  - On rise: cnt <= 1, go COUNT.
  - Level-high s without a rise never starts a measurement. A new measurement therefore needs stop to go low and then high again.
- COUNT:
  - While s=1: cnt <= (cnt == all-ones) ? cnt : cnt+1. The saturation flag is set sticky when an increment is attempted at all-ones.
  - On s=0: dato <= cnt, ovf <= flag, idx <= 0, go SEND.
  - A synchronised high pulse of N cycles yields dato = N when N < 2^CNT_W, else all-ones with ovf=1.
- SEND:
  - tx_data <= selected byte; tx_stt=1 for exactly this one cycle; go WAIT_EOT.
  - tx_data holds stable until the next SEND.
- WAIT_EOT:
  - On tx_eot: if idx == last byte, done=1 for one cycle and go IDLE; else idx <= idx+1 and go SEND.
- Byte order: payload byte k = dato[8k+7:8k], k = 0..NBYTES-1.
- Latency:
  - dato updates on the clock edge where s is first sampled low in COUNT. That is SYNC_STAGES+1 cycles after stop falls at the pin.
  - tx_stt asserts on the following cycle.
  - Each subsequent tx_stt asserts 2 cycles after the accepted tx_eot.
- Ignored inputs:
  - tx_eot outside WAIT_EOT is ignored.
  - stop activity during SEND/WAIT_EOT is ignored. If stop is still high on return to IDLE, there is no rise and no new measurement.
- Register retention: dato/ovf keep their value until the next measurement completes. busy = (state != IDLE).
- Simultaneous events: tx_eot arriving in the same cycle as the SEND→WAIT_EOT transition is not accepted; the transmitter must pulse EOT at least one cycle after STT.
- Illegal/unused state encodings return to IDLE.

Optional Feature:
- Macro TDC_FRAME_HEADER_EN.
- Defined:
  - A header byte is sent before the payload: 8'hA4 | {7'b0, ovf}, i.e. 0xA4 normal, 0xA5 overflow.
  - idx spans 0..NBYTES, with idx 0 the header.
  - done follows the EOT of the last payload byte.
- Undefined: payload only (NBYTES bytes); ovf is reported on its port only.

Test Plan:
- CNT_W=16, stop high 5 cycles, transmitter model pulses EOT 10 cycles after each STT → dato=0x0005, ovf=0, tx_data 0x05 then 0x00, exactly two tx_stt pulses, one done pulse, busy low afterwards.
- CNT_W=8, stop high 300 cycles → dato=0xFF, ovf=1, single byte 0xFF sent; next measurement of 3 cycles → dato=0x03, ovf=0.
- Stop pulse 4 cycles, then stop rises again during WAIT_EOT and stays high → no extra measurement. Then drop stop and pulse it 7 cycles → dato=7.
- Assert reset during WAIT_EOT of byte 0 → dato, ovf, tx_stt, busy, tx_data all 0 without a clock edge. After release, a 9-cycle pulse → dato=9 and a normal two-byte frame.
- tx_eot pulses in IDLE and COUNT → no state change, no done, no tx_stt.
- TDC_FRAME_HEADER_EN, CNT_W=16, 3-cycle pulse → bytes 0xA4, 0x03, 0x00. CNT_W=8 with a saturating pulse → bytes 0xA5, 0xFF.

Source files
------------

// File: rtl/tdc_frame_tx.sv
// Pulse-width TDC: counts synchronised `stop` high time, then ships the latched result LSB byte first via STT/EOT.
// Optional macro TDC_FRAME_HEADER_EN prepends a header byte (0xA4 | ovf) to each frame.
module tdc_frame_tx #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop,
  input  logic             tx_eot,
  output logic [7:0]       tx_data,
  output logic             tx_stt,
  output logic [CNT_W-1:0] dato,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int NBYTES = CNT_W / 8;
`ifdef TDC_FRAME_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NFRAME = NBYTES + HDR;
  localparam logic [2:0] LAST = 3'(NFRAME - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_SEND,
    S_WAIT_EOT
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sd;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_sat;
  logic [2:0]             r_idx;

  logic       w_s;
  logic       w_rise;
  logic [2:0] w_sel;
  logic [7:0] w_byte;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_sd;
  assign busy   = (r_state != S_IDLE);

  // Frame slot -> byte: slot 0 is the header when enabled, payload slots map LSB byte first.
  always_comb begin
    w_sel  = r_idx - 3'(HDR);
    w_byte = 8'(dato >> {w_sel, 3'b000});
`ifdef TDC_FRAME_HEADER_EN
    if (r_idx == 3'd0) w_byte = 8'hA4 | {7'b0, ovf};
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sync  <= '0;
      r_sd    <= 1'b0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_idx   <= '0;
      tx_data <= '0;
      tx_stt  <= 1'b0;
      dato    <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], stop};
      r_sd   <= w_s;
      tx_stt <= 1'b0;
      done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_cnt   <= CNT_W'(1);
            r_sat   <= 1'b0;
            r_state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (w_s) begin
            // Saturate at all-ones; the flag records any increment attempted there.
            if (&r_cnt) r_sat <= 1'b1;
            else        r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            dato    <= r_cnt;
            ovf     <= r_sat;
            r_idx   <= '0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          tx_data <= w_byte;
          tx_stt  <= 1'b1;
          r_state <= S_WAIT_EOT;
        end
        S_WAIT_EOT: begin
          if (tx_eot) begin
            if (r_idx == LAST) begin
              done    <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= S_SEND;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_frame_tx.sv
// Randomised bench for tdc_frame_tx: 16-bit and 8-bit instances share stop, each has its own EOT responder.
// Expected frames come from the pulse length alone (clamp, overflow, byte split).
module tb_tdc_frame_tx;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stop = 1'b0;
  logic eot_spur = 1'b0;
  logic eot16, eot8;
  logic tx_eot16, tx_eot8;

  logic [7:0]  tx_data16, tx_data8;
  logic        tx_stt16, tx_stt8;
  logic [15:0] dato16;
  logic [7:0]  dato8;
  logic        ovf16, ovf8, busy16, busy8, done16, done8;

  int n_checks = 0;
  int n_err    = 0;

  bq_t q16, q8;
  int  ndone16 = 0, ndone8 = 0;
  int  cnt16 = 0, cnt8 = 0;

  always #5 clk = ~clk;

  assign tx_eot16 = eot16 | eot_spur;
  assign tx_eot8  = eot8  | eot_spur;

  tdc_frame_tx #(.CNT_W(16), .SYNC_STAGES(2)) u_dut16 (
    .clk(clk), .reset(reset), .stop(stop), .tx_eot(tx_eot16),
    .tx_data(tx_data16), .tx_stt(tx_stt16), .dato(dato16), .ovf(ovf16),
    .busy(busy16), .done(done16)
  );

  tdc_frame_tx #(.CNT_W(8), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .reset(reset), .stop(stop), .tx_eot(tx_eot8),
    .tx_data(tx_data8), .tx_stt(tx_stt8), .dato(dato8), .ovf(ovf8),
    .busy(busy8), .done(done8)
  );

  // Byte transmitters: one-cycle EOT roughly 10 cycles after each STT.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt16 <= 0; eot16 <= 1'b0;
    end else begin
      eot16 <= 1'b0;
      if (tx_stt16) cnt16 <= 10;
      else if (cnt16 != 0) begin
        cnt16 <= cnt16 - 1;
        if (cnt16 == 1) eot16 <= 1'b1;
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt8 <= 0; eot8 <= 1'b0;
    end else begin
      eot8 <= 1'b0;
      if (tx_stt8) cnt8 <= 10;
      else if (cnt8 != 0) begin
        cnt8 <= cnt8 - 1;
        if (cnt8 == 1) eot8 <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (tx_stt16) q16.push_back(tx_data16);
    if (tx_stt8)  q8.push_back(tx_data8);
    if (done16) ndone16++;
    if (done8)  ndone8++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_dato(input int unsigned n, input int unsigned w);
    longint unsigned maxv = (64'd1 << w) - 1;
    return (longint'(n) > maxv) ? 32'(maxv) : 32'(n);
  endfunction

  function automatic logic exp_ovf(input int unsigned n, input int unsigned w);
    return longint'(n) > ((64'd1 << w) - 1);
  endfunction

  function automatic bq_t frame_bytes(input int unsigned n, input int unsigned w);
    bq_t q;
    logic [31:0] d = exp_dato(n, w);
`ifdef TDC_FRAME_HEADER_EN
    q.push_back(8'hA4 | {7'b0, exp_ovf(n, w)});
`endif
    for (int unsigned k = 0; k < w / 8; k++) q.push_back(8'(d >> (8 * k)));
    return q;
  endfunction

  task automatic clear_mon();
    q16.delete(); q8.delete();
    ndone16 = 0; ndone8 = 0;
  endtask

  task automatic start_pulse(input int unsigned n, input bit spur);
    bq_t e16, e8;
    e16 = frame_bytes(n, 16);
    e8  = frame_bytes(n, 8);
    @(negedge clk);
    clear_mon();
    stop = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      eot_spur = spur && (n >= 4) && (i == n - 1);
      @(negedge clk);
    end
    eot_spur = 1'b0;
    stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("lat_dato16", 32'(dato16), exp_dato(n, 16));
    check("lat_dato8", 32'(dato8), exp_dato(n, 8));
    check("lat_busy16", 32'(busy16), 32'd1);
    check("lat_stt_early", 32'(tx_stt16), 32'd0);
    @(posedge clk);
    #1;
    check("stt16", 32'(tx_stt16), 32'd1);
    check("stt8", 32'(tx_stt8), 32'd1);
    check("byte0_16", 32'(tx_data16), 32'(e16[0]));
    check("byte0_8", 32'(tx_data8), 32'(e8[0]));
  endtask

  task automatic finish_frame(input int unsigned n);
    bq_t e16, e8;
    int unsigned budget;
    e16 = frame_bytes(n, 16);
    e8  = frame_bytes(n, 8);
    budget = 0;
    while ((busy16 || busy8) && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    check("idle_timeout", 32'(busy16 | busy8), 32'd0);
    repeat (2) @(negedge clk);
    check("dato16", 32'(dato16), exp_dato(n, 16));
    check("ovf16", 32'(ovf16), 32'(exp_ovf(n, 16)));
    check("dato8", 32'(dato8), exp_dato(n, 8));
    check("ovf8", 32'(ovf8), 32'(exp_ovf(n, 8)));
    check("done16_cnt", 32'(ndone16), 32'd1);
    check("done8_cnt", 32'(ndone8), 32'd1);
    check("nbytes16", 32'(q16.size()), 32'(e16.size()));
    check("nbytes8", 32'(q8.size()), 32'(e8.size()));
    for (int i = 0; i < e16.size() && i < q16.size(); i++) check("frame16", 32'(q16[i]), 32'(e16[i]));
    for (int i = 0; i < e8.size() && i < q8.size(); i++) check("frame8", 32'(q8[i]), 32'(e8[i]));
  endtask

  task automatic full(input int unsigned n, input bit spur);
    start_pulse(n, spur);
    finish_frame(n);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check("rst_dato16", 32'(dato16), 32'd0);
    check("rst_stt16", 32'(tx_stt16), 32'd0);
    check("rst_busy16", 32'(busy16), 32'd0);
    check("rst_data8", 32'(tx_data8), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // EOT noise while idle must not start anything.
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      eot_spur = 1'b1;
      @(negedge clk);
      eot_spur = 1'b0;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("idle_eot_busy", 32'(busy16 | busy8), 32'd0);
    check("idle_eot_stt", 32'(q16.size() + q8.size()), 32'd0);
    check("idle_eot_done", 32'(ndone16 + ndone8), 32'd0);

    full(5, 1'b1);
    full(300, 1'b1);
    full(3, 1'b0);
    full(255, 1'b0);
    full(256, 1'b0);

    // stop rising during WAIT_EOT and held high must not retrigger.
    start_pulse(4, 1'b0);
    repeat (3) @(negedge clk);
    stop = 1'b1;
    finish_frame(4);
    clear_mon();
    repeat (30) @(negedge clk);
    check("held_busy", 32'(busy16 | busy8), 32'd0);
    check("held_stt", 32'(q16.size() + q8.size()), 32'd0);
    check("held_dato16", 32'(dato16), 32'd4);
    stop = 1'b0;
    repeat (5) @(negedge clk);
    full(7, 1'b0);

    // Asynchronous reset mid-frame, then a clean frame afterwards.
    start_pulse(20, 1'b0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_dato16", 32'(dato16), 32'd0);
    check("arst_ovf8", 32'(ovf8), 32'd0);
    check("arst_stt16", 32'(tx_stt16), 32'd0);
    check("arst_busy", 32'(busy16 | busy8), 32'd0);
    check("arst_data16", 32'(tx_data16), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    full(9, 1'b0);

    for (int r = 0; r < 10; r++) begin
      int unsigned n;
      n = $urandom_range(1, 60);
      if ($urandom_range(0, 4) == 0) n = $urandom_range(250, 270);
      repeat ($urandom_range(2, 6)) @(negedge clk);
      full(n, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
